// File: rtl/pwm_demod_pkg.sv
// Shared constants and state encoding for the PWM demodulator.
// Default widths track the PWM generator's top-level width parameters.
package pwm_demod_pkg;

    localparam int M_DEF    = 12;
    localparam int CW_DEF   = 16;
    localparam int SYNC_DEF = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/pwm_div.sv
// Restoring unsigned divider producing (num_hi << M) / den, one quotient bit per cycle.
// busy stays high through the done cycle so a new start can only land after results are taken.
module pwm_div
    import pwm_demod_pkg::*;
#(
    parameter int M  = M_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] num_hi,
    input  logic [CW-1:0] den,
    output logic          busy,
    output logic          done,
    output logic [M-1:0]  q
);

    localparam int CNTW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(M - 1);

    logic [CW-1:0]   rem;
    logic [CW-1:0]   den_r;
    logic [M-1:0]    q_r;
    logic [CNTW-1:0] cnt;
    logic            running;
    logic            done_r;
    logic [CW:0]     rem_sh;
    logic [CW:0]     rem_diff;
    logic            qbit;

    // num_hi < den keeps the remainder below den, so CW+1 bits hold the shifted value.
    always_comb begin
        rem_sh   = {rem, 1'b0};
        qbit     = (rem_sh >= {1'b0, den_r});
        rem_diff = rem_sh - {1'b0, den_r};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem     <= '0;
            den_r   <= '0;
            q_r     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                rem     <= num_hi;
                den_r   <= den;
                q_r     <= '0;
                cnt     <= '0;
                running <= 1'b1;
            end else if (running) begin
                rem <= qbit ? rem_diff[CW-1:0] : rem_sh[CW-1:0];
                q_r <= {q_r[M-2:0], qbit};
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    running <= 1'b0;
                    done_r  <= 1'b1;
                end
            end
        end
    end

    assign busy = running | done_r;
    assign done = done_r;
    assign q    = q_r;

endmodule

// File: rtl/pwm_demod.sv
// PWM demodulator: synchronizes a PWM stream, measures period and high time between rises,
// and reports duty = floor(high * 2^M / period), with a timeout for a stuck input.
module pwm_demod
    import pwm_demod_pkg::*;
#(
    parameter int M           = M_DEF,
    parameter int CW          = CW_DEF,
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    output logic [M-1:0]  duty,
    output logic [CW-1:0] period,
    output logic          duty_valid,
    output logic          stuck,
    output logic          missed
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t               state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                 level, level_d, rise;
    logic [CW-1:0]        period_cnt, high_cnt, per_lat;
    logic                 start, drop, timeout;
    logic                 div_busy, div_done;
    logic [M-1:0]         div_q;

    // Sync chain resets low, so an input already high at reset release reads as a rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync    <= '0;
            level_d <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], pwm_in};
            level_d <= level;
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~level_d;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Timeout wins over a rise arriving in the same cycle.
    always_comb begin
        state_n = state;
        start   = 1'b0;
        drop    = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_n = MEASURE;
            end
            MEASURE: begin
                if (period_cnt == CNT_MAX) begin
                    timeout = 1'b1;
                    state_n = IDLE;
                end else if (rise) begin
                    if (div_busy) drop  = 1'b1;
                    else          start = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The rise cycle is the first cycle of the new period; counters hold (saturate) in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            per_lat    <= '0;
        end else begin
            if (start) per_lat <= period_cnt;
            if (rise && !timeout) begin
                period_cnt <= {{(CW-1){1'b0}}, 1'b1};
                high_cnt   <= {{(CW-1){1'b0}}, 1'b1};
            end else if (state == MEASURE && !timeout) begin
                period_cnt <= period_cnt + 1'b1;
                if (level) high_cnt <= high_cnt + 1'b1;
            end
        end
    end

    pwm_div #(.M(M), .CW(CW)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .num_hi (high_cnt),
        .den    (period_cnt),
        .busy   (div_busy),
        .done   (div_done),
        .q      (div_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty       <= '0;
            period     <= '0;
            duty_valid <= 1'b0;
            stuck      <= 1'b0;
            missed     <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            stuck      <= 1'b0;
            missed     <= drop;
            if (timeout) begin
                duty       <= level ? {M{1'b1}} : '0;
                period     <= CNT_MAX;
                duty_valid <= 1'b1;
                stuck      <= 1'b1;
            end else if (div_done) begin
                duty       <= div_q;
                period     <= per_lat;
                duty_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_demod.sv
// Self-checking bench for pwm_demod: PWM driver, scoreboard queue of expected strobes, report.
// CW is 15 here: 2^15 still exceeds the 16384-cycle generator period and halves the timeout run.
module tb_pwm_demod;

    localparam int M  = 12;
    localparam int CW = 15;
    localparam int S  = 2;
    localparam int EW = 32 + 1 + CW + M;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pwm_in = 1'b0;
    logic [M-1:0]  duty;
    logic [CW-1:0] period;
    logic          duty_valid, stuck, missed;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int unexpected = 0;
    int missed_cnt = 0;
    int fixed_valid = 0;
    bit fixed_mode = 1'b0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] e;

    pwm_demod #(.M(M), .CW(CW), .SYNC_STAGES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .period     (period),
        .duty_valid (duty_valid),
        .stuck      (stuck),
        .missed     (missed)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [M-1:0] model_duty(input int hi, input int per);
        longint num;
        num = longint'(hi) << M;
        return M'(num / per);
    endfunction

    task automatic push_exp(input logic [M-1:0] d, input logic [CW-1:0] p, input logic s, input int edge_no);
        exp_q.push_back({edge_no[31:0], s, p, d});
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // n full periods framed by n+1 rises; each closing rise pushes the expected result
    // along with the edge that first samples it high.
    task automatic gen(input int hi, input int per, input int n, input bit push_en, input bit hold);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < per; c++) begin
                @(negedge clk);
                pwm_in = (c < hi);
                if (c == 0 && p > 0 && push_en)
                    push_exp(model_duty(hi, per), CW'(per), 1'b0, cyc + 1);
            end
        end
        @(negedge clk);
        pwm_in = 1'b1;
        if (push_en) push_exp(model_duty(hi, per), CW'(per), 1'b0, cyc + 1);
        if (!hold) begin
            @(negedge clk);
            pwm_in = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    // scoreboard: compare every strobe against the head of the expected queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (missed) missed_cnt++;
            if (duty_valid) begin
                if (fixed_mode) begin
                    fixed_valid++;
                    check("fast_duty", duty, 12'h800);
                    check("fast_period", period, 10);
                    check("fast_stuck", stuck, 0);
                end else if (exp_q.size() == 0) begin
                    unexpected++;
                end else begin
                    e = exp_q.pop_front();
                    check("duty", duty, e[M-1:0]);
                    check("period", period, e[M+CW-1:M]);
                    check("stuck", stuck, e[M+CW]);
                    if (e[EW-1 -: 32] != 0) check("latency", cyc, e[EW-1 -: 32] + S + M + 1);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_duty", duty, 0);
        check("rst_period", period, 0);
        check("rst_valid", duty_valid, 0);
        check("rst_stuck", stuck, 0);
        check("rst_missed", missed, 0);
        rst_n = 1'b1;

        // generator loopback: period 16384, high 4096
        apply_reset();
        gen(4096, 16384, 1, 1'b1, 1'b0);
        wait_drain("t1_drain", 100);

        // 50% square wave, period 100
        apply_reset();
        missed_cnt = 0;
        gen(50, 100, 3, 1'b1, 1'b0);
        wait_drain("t2_drain", 100);
        check("t2_missed", missed_cnt, 0);

        // extreme duty codes
        apply_reset();
        gen(1, 4096, 1, 1'b1, 1'b0);
        wait_drain("t3a_drain", 100);
        apply_reset();
        gen(4095, 4096, 1, 1'b1, 1'b0);
        wait_drain("t3b_drain", 100);

        // stuck-high timeout, then recovery
        apply_reset();
        gen(50, 100, 2, 1'b1, 1'b1);
        push_exp({M{1'b1}}, {CW{1'b1}}, 1'b1, 0);
        wait_drain("t4_timeout", (1 << CW) + 400);
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (40) @(negedge clk);
        gen(50, 100, 1, 1'b1, 1'b0);
        wait_drain("t4_resume", 100);

        // period shorter than M+2: every other closing rise is dropped
        apply_reset();
        missed_cnt  = 0;
        fixed_valid = 0;
        fixed_mode  = 1'b1;
        gen(5, 10, 20, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        fixed_mode = 1'b0;
        check("t5_valids", fixed_valid, 10);
        check("t5_missed", missed_cnt, 10);

        // reset in the middle of a divide
        apply_reset();
        gen(50, 100, 2, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t6_duty", duty, 0);
        check("t6_period", period, 0);
        check("t6_valid", duty_valid, 0);
        check("t6_stuck", stuck, 0);
        check("t6_missed", missed, 0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_no_abort_valid", unexpected, 0);
        gen(50, 100, 2, 1'b1, 1'b0);
        wait_drain("t6_resume", 100);

        repeat (20) @(negedge clk);
        check("no_unexpected_valid", unexpected, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
